// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;

    // x0 is hard-wired to zero, so a load targeting it never creates a hazard.
    localparam logic [REG_ADDR_W-1:0] REG_X0 = '0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StMemWait,
        StError
    } pipe_state_e;

    // True when an enabled source operand matches the producing register.
    function automatic logic src_hit(
        input logic                  rd_en,
        input logic [REG_ADDR_W-1:0] src,
        input logic [REG_ADDR_W-1:0] dst
    );
        return rd_en && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment on request, holding at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: run gating, load-use stall, branch flush, data-memory
// freeze with watchdog, and saturating stall/flush event counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_use_i,
    input  logic                  id_rs2_use_i,
    input  logic                  ex_memrd_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  mem_pcsrc_i,
    input  logic                  mem_req_i,
    input  logic                  dmem_ready_i,
    output logic                  pc_we_o,
    output logic                  if_id_we_o,
    output logic                  id_ex_we_o,
    output logic                  ex_mem_we_o,
    output logic                  mem_wb_we_o,
    output logic                  id_ex_bubble_o,
    output logic                  if_id_flush_o,
    output logic                  id_ex_flush_o,
    output logic                  ex_mem_flush_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic [CNT_W-1:0]      stall_cnt_o,
    output logic [CNT_W-1:0]      flush_cnt_o,
    output logic                  err_o
);

    localparam int unsigned WaitW = $clog2(MEM_TIMEOUT + 1);

    pipe_state_e      state_q, state_d;
    logic [WaitW-1:0] wait_q, wait_d;
    logic             err_q, err_d;

    logic freeze;
    logic load_use;
    logic decode;
    logic [4:0] we;

    assign freeze   = mem_req_i && !dmem_ready_i;
    assign load_use = ex_memrd_i && (ex_rd_i != REG_X0) &&
                      (src_hit(id_rs1_use_i, id_rs1_i, ex_rd_i) ||
                       src_hit(id_rs2_use_i, id_rs2_i, ex_rd_i));

    // Next-state and control decode; controls follow the current inputs so a
    // hazard is handled in the cycle it appears.
    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        err_d          = err_q;
        decode         = 1'b0;
        we             = 5'b00000;
        id_ex_bubble_o = 1'b0;
        if_id_flush_o  = 1'b0;
        id_ex_flush_o  = 1'b0;
        ex_mem_flush_o = 1'b0;
        stall_o        = 1'b0;
        flush_o        = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                wait_d = '0;
                if (!start_i) begin
                    state_d = StIdle;
                end else if (freeze) begin
                    // The first frozen cycle already counts toward the timeout.
                    state_d = StMemWait;
                    wait_d  = WaitW'(1);
                end else begin
                    decode = 1'b1;
                end
            end
            StMemWait: begin
                if (freeze) begin
                    if (wait_q >= WaitW'(MEM_TIMEOUT - 1)) begin
                        state_d = StError;
                        err_d   = 1'b1;
                    end else begin
                        wait_d = wait_q + WaitW'(1);
                    end
                end else begin
                    // Memory answered: the pipeline advances in this same cycle.
                    state_d = StRun;
                    wait_d  = '0;
                    decode  = 1'b1;
                end
            end
            StError: begin
                state_d = StError;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (decode) begin
            we = 5'b11111;
            if (mem_pcsrc_i) begin
                // Flush outranks load-use: the stalled instruction is squashed anyway.
                if_id_flush_o  = 1'b1;
                id_ex_flush_o  = 1'b1;
                ex_mem_flush_o = 1'b1;
                flush_o        = 1'b1;
            end else if (load_use) begin
                we[4]          = 1'b0;
                we[3]          = 1'b0;
                id_ex_bubble_o = 1'b1;
                stall_o        = 1'b1;
            end
        end
    end

    assign pc_we_o     = we[4];
    assign if_id_we_o  = we[3];
    assign id_ex_we_o  = we[2];
    assign ex_mem_we_o = we[1];
    assign mem_wb_we_o = we[0];
    assign err_o       = err_q;

    // State, watchdog and sticky error registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_o),
        .cnt_o   (stall_cnt_o)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (flush_o),
        .cnt_o   (flush_cnt_o)
    );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with small counters and a short watchdog.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 2;
    localparam int unsigned TO = 4;

    typedef struct packed {
        logic [4:0]    we;     // {pc, if_id, id_ex, ex_mem, mem_wb}
        logic          bub;
        logic [2:0]    fl;     // {if_id, id_ex, ex_mem}
        logic          st;
        logic          fs;
        logic [CW-1:0] sc;
        logic [CW-1:0] fc;
        logic          err;
    } exp_t;

    localparam logic [4:0] WE0 = 5'b00000;
    localparam logic [4:0] WE1 = 5'b11111;
    localparam logic [4:0] WES = 5'b00111;

    logic clk = 1'b0;
    logic rst_n, start, rs1_use, rs2_use, memrd, pcsrc, req, rdy;
    logic [4:0] rs1, rs2, rd;
    logic pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, bubble;
    logic if_id_fl, id_ex_fl, ex_mem_fl, stall, flush, err;
    logic [CW-1:0] scnt, fcnt;

    exp_t  exp_q[$];
    string name_q[$];
    exp_t  act, e_mon;
    string n_mon;
    int    n_cmp = 0;
    int    n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .CNT_W       (CW),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .start_i        (start),
        .id_rs1_i       (rs1),
        .id_rs2_i       (rs2),
        .id_rs1_use_i   (rs1_use),
        .id_rs2_use_i   (rs2_use),
        .ex_memrd_i     (memrd),
        .ex_rd_i        (rd),
        .mem_pcsrc_i    (pcsrc),
        .mem_req_i      (req),
        .dmem_ready_i   (rdy),
        .pc_we_o        (pc_we),
        .if_id_we_o     (if_id_we),
        .id_ex_we_o     (id_ex_we),
        .ex_mem_we_o    (ex_mem_we),
        .mem_wb_we_o    (mem_wb_we),
        .id_ex_bubble_o (bubble),
        .if_id_flush_o  (if_id_fl),
        .id_ex_flush_o  (id_ex_fl),
        .ex_mem_flush_o (ex_mem_fl),
        .stall_o        (stall),
        .flush_o        (flush),
        .stall_cnt_o    (scnt),
        .flush_cnt_o    (fcnt),
        .err_o          (err)
    );

    always_comb begin
        act = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we, bubble,
               if_id_fl, id_ex_fl, ex_mem_fl, stall, flush, scnt, fcnt, err};
    end

    // Monitor: one expected entry per cycle, compared mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e_mon = exp_q.pop_front();
            n_mon = name_q.pop_front();
            n_cmp = n_cmp + 1;
            if (act !== e_mon) begin
                n_bad = n_bad + 1;
                $display("FAIL %s: got we=%b bub=%b fl=%b st=%b fs=%b sc=%0d fc=%0d err=%b, want we=%b bub=%b fl=%b st=%b fs=%b sc=%0d fc=%0d err=%b",
                         n_mon, act.we, act.bub, act.fl, act.st, act.fs, act.sc, act.fc, act.err,
                         e_mon.we, e_mon.bub, e_mon.fl, e_mon.st, e_mon.fs, e_mon.sc, e_mon.fc,
                         e_mon.err);
            end
        end
    end

    function automatic exp_t mk(input logic [4:0] w, input logic b, input logic [2:0] f,
                                input logic s, input logic fl, input int sc, input int fc,
                                input logic er);
        exp_t e;
        e.we  = w;
        e.bub = b;
        e.fl  = f;
        e.st  = s;
        e.fs  = fl;
        e.sc  = CW'(sc);
        e.fc  = CW'(fc);
        e.err = er;
        return e;
    endfunction

    task automatic clr();
        rs1 = 5'd0; rs2 = 5'd0; rs1_use = 1'b0; rs2_use = 1'b0;
        memrd = 1'b0; rd = 5'd0; pcsrc = 1'b0; req = 1'b0; rdy = 1'b0;
    endtask

    // Queue the expectation for the inputs now applied, then advance one cycle.
    task automatic chk(input string nm, input exp_t e);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_idle",   mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        start = 1'b1;
        chk("start_idle",   mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        chk("run_default",  mk(WE1, 0, 3'b000, 0, 0, 0, 0, 0));

        memrd = 1'b1; rd = 5'd5; rs2 = 5'd5; rs2_use = 1'b1;
        chk("load_use_rs2", mk(WES, 1, 3'b000, 1, 0, 0, 0, 0));
        clr();
        chk("after_stall",  mk(WE1, 0, 3'b000, 0, 0, 1, 0, 0));
        memrd = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_use = 1'b1; rs2 = 5'd0; rs2_use = 1'b1;
        chk("load_x0",      mk(WE1, 0, 3'b000, 0, 0, 1, 0, 0));
        clr();
        memrd = 1'b1; rd = 5'd7; rs1 = 5'd7; rs2 = 5'd3; rs2_use = 1'b1;
        chk("rs1_unused",   mk(WE1, 0, 3'b000, 0, 0, 1, 0, 0));
        rs1_use = 1'b1;
        chk("load_use_rs1", mk(WES, 1, 3'b000, 1, 0, 1, 0, 0));

        clr();
        pcsrc = 1'b1; memrd = 1'b1; rd = 5'd3; rs1 = 5'd3; rs1_use = 1'b1;
        chk("flush_wins",   mk(WE1, 0, 3'b111, 0, 1, 2, 0, 0));
        clr();
        chk("after_flush",  mk(WE1, 0, 3'b000, 0, 0, 2, 1, 0));

        req = 1'b1; rdy = 1'b0; pcsrc = 1'b1;
        chk("freeze_1",     mk(WE0, 0, 3'b000, 0, 0, 2, 1, 0));
        chk("freeze_2",     mk(WE0, 0, 3'b000, 0, 0, 2, 1, 0));
        chk("freeze_3",     mk(WE0, 0, 3'b000, 0, 0, 2, 1, 0));
        rdy = 1'b1;
        chk("resume_flush", mk(WE1, 0, 3'b111, 0, 1, 2, 1, 0));
        clr();
        chk("after_resume", mk(WE1, 0, 3'b000, 0, 0, 2, 2, 0));

        memrd = 1'b1; rd = 5'd9; rs2 = 5'd9; rs2_use = 1'b1;
        chk("sat_stall_a",  mk(WES, 1, 3'b000, 1, 0, 2, 2, 0));
        chk("sat_stall_b",  mk(WES, 1, 3'b000, 1, 0, 3, 2, 0));
        chk("sat_stall_c",  mk(WES, 1, 3'b000, 1, 0, 3, 2, 0));
        clr();
        chk("stall_sat",    mk(WE1, 0, 3'b000, 0, 0, 3, 2, 0));

        memrd = 1'b1; rd = 5'd9; rs2 = 5'd9; rs2_use = 1'b1; start = 1'b0;
        chk("stop_idle",    mk(WE0, 0, 3'b000, 0, 0, 3, 2, 0));
        clr();
        chk("idle_hold",    mk(WE0, 0, 3'b000, 0, 0, 3, 2, 0));
        start = 1'b1;
        chk("restart_idle", mk(WE0, 0, 3'b000, 0, 0, 3, 2, 0));
        chk("restart_run",  mk(WE1, 0, 3'b000, 0, 0, 3, 2, 0));

        req = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("timeout_wait", mk(WE0, 0, 3'b000, 0, 0, 3, 2, 0));
        end
        rdy = 1'b1; pcsrc = 1'b1;
        chk("error_sticky", mk(WE0, 0, 3'b000, 0, 0, 3, 2, 1));
        clr();
        start = 1'b0;
        chk("error_nostart", mk(WE0, 0, 3'b000, 0, 0, 3, 2, 1));
        rst_n = 1'b0;
        chk("reset_in_err", mk(WE0, 0, 3'b000, 0, 0, 3, 2, 1));
        rst_n = 1'b1;
        chk("post_reset",   mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));

        start = 1'b1;
        chk("mw_idle",      mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        chk("mw_run",       mk(WE1, 0, 3'b000, 0, 0, 0, 0, 0));
        req = 1'b1; rdy = 1'b0;
        chk("mw_freeze_a",  mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        chk("mw_freeze_b",  mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        chk("mw_rst_cycle", mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        clr();
        start = 1'b0;
        chk("mw_post_rst",  mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        start = 1'b1;
        chk("mw_idle2",     mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        req = 1'b1; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mw_wait3", mk(WE0, 0, 3'b000, 0, 0, 0, 0, 0));
        end
        rdy = 1'b1;
        chk("mw_resume",    mk(WE1, 0, 3'b000, 0, 0, 0, 0, 0));
        clr();
        chk("mw_no_error",  mk(WE1, 0, 3'b000, 0, 0, 0, 0, 0));

        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_bad = n_bad + 1;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
